mac_operand_sender: RTL and testbench
=====================================

# mac_operand_sender

Initiator side of the three-beat multiply-accumulate interface. Accepts one operand triple (a, b, c) per request over a valid/ready handshake. Serialises the triple onto `validi`/`data_in` as three consecutive high cycles, then waits for `valido` and returns the captured `data_out` (expected a*b+c) to the requester. Sits between the test/control logic and the MAC responder and shares their clock and reset.

## Interface
- `WIDTH`, 32, operand/result width
- `TIMEOUT`, 8, max cycles in WAIT before declaring no response (≥1)

- `clk` in 1: clock, all logic on rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in 1: operand triple offered
- `req_ready` out 1: sender can accept a triple
- `a`, `b`, `c` in WIDTH each: operands, sampled on acceptance
- `validi` out 1: beat valid to MAC
- `data_in` out WIDTH: beat data to MAC
- `valido` in 1: MAC result valid
- `data_out` in WIDTH: MAC result
- `res_valid` out 1: result available
- `res_ready` in 1: requester takes result
- `res_data` out WIDTH: captured result
- `res_err` out 1: result is a timeout (no `valido` seen)
- `proto_err` out 1: sticky, `valido` seen outside WAIT
- `txn_cnt` out 16: completed transactions (ok + timeout), wraps 0xFFFF→0

## Operation
- States: IDLE, SEND_A, SEND_B, SEND_C, WAIT, DONE.
- IDLE: `req_ready`=1. On `req_valid`, register a/b/c → SEND_A.
- SEND_A/B/C: `validi`=1, `data_in`=a/b/c respectively. Each lasts exactly one cycle, in order.
- WAIT: `validi`=0, `data_in`=0. Timeout counter starts at 0 on entry and increments each WAIT cycle.
  - On `valido`=1: register `data_out` into `res_data`, `res_err`=0 → DONE.
  - Else if counter reaches TIMEOUT-1: `res_data`=0, `res_err`=1 → DONE.
  - If `valido` and timeout coincide, `valido` wins.
- DONE: `res_valid`=1, with `res_data`/`res_err` held stable. On `res_ready`: `txn_cnt`+1 → IDLE.
- Outside SEND_*: `validi`=0 and `data_in`=0, always.
- `proto_err`:
  - Set when `valido`=1 in any state other than WAIT.
  - Cleared only by `rst`.
  - Does not alter the FSM.
- No arithmetic is done here. `res_data` is `data_out` verbatim, so any WIDTH truncation is the MAC's.

## Timing
- Reset (async assert, sync release) clears everything:
  - state = IDLE, `req_ready`=0 while `rst` high
  - `validi`, `data_in`, `res_valid`, `res_data`, `res_err`, `proto_err`, `txn_cnt` = 0
- Reset mid-operation abandons the transaction immediately. No result is produced and `txn_cnt` is unchanged.
- Cycle map, with acceptance edge = cycle 0:
  - `validi` high in cycles 1, 2, 3
  - cycle 4 is the first WAIT cycle
- `valido` in WAIT cycle k (k = 0..TIMEOUT-1) → `res_valid` high from the next cycle.
  - Fastest result: `res_valid` at cycle 5 after acceptance.
- Timeout: `res_valid` at cycle 4+TIMEOUT when `valido` is never seen.
- `validi` never runs more than 3 consecutive high cycles.
- Minimum low gap between triples is 3 cycles (WAIT, DONE, IDLE). This prevents the MAC re-triggering on a sliding window.
- `req_ready` is registered from state. A request is never accepted in the same cycle `res_ready` retires DONE.
- Throughput: one triple per ≥6 cycles.

## Test plan
- Basic: a=3, b=4, c=5, MAC answers 17 one cycle after SEND_C → `data_in` sequence 3, 4, 5 on consecutive cycles; `res_data`=17, `res_err`=0, `txn_cnt`=1.
- Wrap: a=0x0001_0000, b=0x0001_0000, c=1, WIDTH=32 → `res_data`=0x0000_0001 (passed through from MAC).
- Timeout: MAC `valido` held 0, TIMEOUT=8 → `res_valid` at cycle 12 after acceptance, `res_err`=1, `res_data`=0.
- Backpressure: hold `res_ready`=0 for 10 cycles in DONE → `res_valid`/`res_data` stable, `req_ready`=0, `validi`=0 throughout.
- Back-to-back: two requests (1,2,3) then (5,6,7), `req_valid` and `res_ready` held 1 → results 5 then 37; ≥3 low `validi` cycles between triples; `txn_cnt`=2.
- Reset mid-SEND_B → `validi`, `data_in`, `res_valid` = 0 asynchronously; after release `req_ready`=1 and `txn_cnt`=0. A `valido` injected in IDLE sets `proto_err`=1.

Source files
------------

// File: rtl/mac_operand_sender.sv
// Purpose: initiator for the three-beat MAC interface; serialises an (a, b, c) triple onto validi/data_in and returns the MAC's result.
// Latency: validi high 1..3 cycles after acceptance; res_valid 5 cycles after acceptance at best, 4+TIMEOUT on timeout.
// Backpressure: req_ready drops while a triple is in flight; DONE holds res_* stable until res_ready, one triple per >=6 cycles.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   req_valid/req_ready, a, b, c  operand triple handshake from the requester
//   validi, data_in               beat stream to the MAC responder
//   valido, data_out              result from the MAC responder
//   res_valid/res_ready           result handshake to the requester
//   res_data, res_err             captured result; res_err marks a timeout
//   proto_err                     sticky flag: valido seen outside WAIT
//   txn_cnt                       completed transactions, wraps at 16 bits
module mac_operand_sender #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    output logic             validi,
    output logic [WIDTH-1:0] data_in,
    input  logic             valido,
    input  logic [WIDTH-1:0] data_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_err,
    output logic             proto_err,
    output logic [15:0]      txn_cnt
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SEND_A = 3'd1;
    localparam logic [2:0] S_SEND_B = 3'd2;
    localparam logic [2:0] S_SEND_C = 3'd3;
    localparam logic [2:0] S_WAIT   = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // Counter only needs to reach TIMEOUT-1; keep at least one bit so TIMEOUT=1 still elaborates.
    localparam int            CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] c;
    } triple_t;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    triple_t       ops_q;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          wait_last;

    assign accept    = (state == S_IDLE) && req_valid && req_ready;
    assign wait_last = (wait_cnt == TO_LAST);
    assign res_valid = (state == S_DONE);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (accept) state_nxt = S_SEND_A;
            S_SEND_A: state_nxt = S_SEND_B;
            S_SEND_B: state_nxt = S_SEND_C;
            S_SEND_C: state_nxt = S_WAIT;
            // A late valido on the last WAIT cycle still counts as a real answer.
            S_WAIT:   if (valido || wait_last) state_nxt = S_DONE;
            S_DONE:   if (res_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Beat outputs decode straight from state so an async reset drops them immediately.
    always_comb begin
        validi  = 1'b0;
        data_in = '0;
        case (state)
            S_SEND_A: begin validi = 1'b1; data_in = ops_q.a; end
            S_SEND_B: begin validi = 1'b1; data_in = ops_q.b; end
            S_SEND_C: begin validi = 1'b1; data_in = ops_q.c; end
            default:  ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            req_ready <= 1'b0;
            ops_q     <= '0;
            wait_cnt  <= '0;
            res_data  <= '0;
            res_err   <= 1'b0;
            proto_err <= 1'b0;
            txn_cnt   <= 16'd0;
        end else begin
            state <= state_nxt;
            // Registered from the next state: low during reset, never high in the
            // cycle DONE retires, so a new request always sees one IDLE cycle first.
            req_ready <= (state_nxt == S_IDLE);

            if (accept) begin
                ops_q <= '{a: a, b: b, c: c};
            end

            if (state == S_SEND_C) begin
                wait_cnt <= '0;
            end else if (state == S_WAIT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            if (state == S_WAIT) begin
                if (valido) begin
                    res_data <= data_out;
                    res_err  <= 1'b0;
                end else if (wait_last) begin
                    res_data <= '0;
                    res_err  <= 1'b1;
                end
            end

            if (valido && (state != S_WAIT)) begin
                proto_err <= 1'b1;
            end

            if ((state == S_DONE) && res_ready) begin
                txn_cnt <= txn_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_mac_operand_sender.sv
// Purpose: directed bench for mac_operand_sender with a result scoreboard and a validi run-length monitor.
// Latency: checks exact beat cycles, result cycle (fast, mid, coincident, timeout) and backpressure hold.
// Backpressure: res_ready held low in DONE for one transaction; others retire at once for minimum-gap back-to-back traffic.
module tb_mac_operand_sender;

    localparam int W  = 32;
    localparam int TO = 8;

    typedef struct packed {
        logic         err;
        logic [W-1:0] data;
    } res_t;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic         validi;
    logic [W-1:0] data_in;
    logic         valido;
    logic [W-1:0] data_out;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_err;
    logic         proto_err;
    logic [15:0]  txn_cnt;

    mac_operand_sender #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .validi    (validi),
        .data_in   (data_in),
        .valido    (valido),
        .data_out  (data_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_err   (res_err),
        .proto_err (proto_err),
        .txn_cnt   (txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_fail   = 0;
    res_t        sb[$];
    logic [15:0] exp_txn  = 16'd0;

    // validi run-length monitor: longest high run and shortest low gap between triples.
    int   hi_run  = 0;
    int   lo_run  = 0;
    int   max_hi  = 0;
    int   min_gap = 1000;
    logic seen_hi = 1'b0;

    always @(negedge clk) begin
        if (validi === 1'b1) begin
            if (hi_run == 0 && seen_hi && lo_run < min_gap) min_gap = lo_run;
            hi_run  = hi_run + 1;
            lo_run  = 0;
            seen_hi = 1'b1;
            if (hi_run > max_hi) max_hi = hi_run;
        end else begin
            hi_run = 0;
            lo_run = lo_run + 1;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog expired checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One full transaction starting at a negedge. dly = WAIT cycle index at which the
    // MAC answers (-1: never). hold = cycles res_ready stays low once DONE is reached.
    task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic [W-1:0] tc,
                           input int dly, input logic [W-1:0] mac_res, input int hold);
        int   cyc;
        int   exp_cyc;
        logic got;
        res_t exp_r;
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        check("req_ready_before_req", req_ready, 1);
        req_valid = 1'b1;
        a = ta; b = tb_; c = tc;
        sb.push_back('{err: (dly < 0), data: ((dly < 0) ? '0 : mac_res)});
        exp_cyc = (dly < 0) ? (4 + TO) : (5 + dly);

        @(negedge clk); cyc = 1;
        req_valid = 1'b0;
        check("beat_a_validi", validi, 1);
        check("beat_a_data", data_in, ta);
        check("busy_req_ready", req_ready, 0);
        @(negedge clk); cyc = 2;
        check("beat_b_validi", validi, 1);
        check("beat_b_data", data_in, tb_);
        @(negedge clk); cyc = 3;
        check("beat_c_validi", validi, 1);
        check("beat_c_data", data_in, tc);

        got = 1'b0;
        for (int k = 0; k < TO + 3; k++) begin
            @(negedge clk); cyc++;
            valido = 1'b0;
            if (res_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
            check("wait_beat_idle", {validi, data_in}, 0);
            if (k == dly) begin
                valido   = 1'b1;
                data_out = mac_res;
            end
        end
        valido = 1'b0;
        check("res_valid_seen", got, 1);
        check("res_valid_cycle", cyc, exp_cyc);
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
            exp_r = sb.pop_front();
            check("res_data", res_data, exp_r.data);
            check("res_err", res_err, exp_r.err);
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                check("hold_res_valid", res_valid, 1);
                check("hold_res_data", res_data, exp_r.data);
                check("hold_req_ready", req_ready, 0);
                check("hold_validi", validi, 0);
            end
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        exp_txn   = exp_txn + 16'd1;
        check("retire_res_valid", res_valid, 0);
        check("retire_txn_cnt", txn_cnt, exp_txn);
        check("retire_req_ready", req_ready, 1);
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; a = '0; b = '0; c = '0;
        valido = 1'b0; data_out = '0; res_ready = 1'b0;
        #1 rst = 1'b1;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_validi", validi, 0);
        check("rst_data_in", data_in, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_err", res_err, 0);
        check("rst_proto_err", proto_err, 0);
        check("rst_txn_cnt", txn_cnt, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", req_ready, 1);

        // Basic, wrap with backpressure, timeout, coincident valido/timeout, back-to-back
        run_txn(32'd3, 32'd4, 32'd5, 0, 32'd17, 0);
        run_txn(32'h0001_0000, 32'h0001_0000, 32'd1, 2, 32'h0000_0001, 10);
        run_txn(32'd7, 32'd7, 32'd7, -1, 32'hDEAD_BEEF, 0);
        run_txn(32'd2, 32'd3, 32'd4, TO - 1, 32'd10, 0);
        run_txn(32'd1, 32'd2, 32'd3, 0, 32'd5, 0);
        run_txn(32'd5, 32'd6, 32'd7, 0, 32'd37, 0);
        check("no_proto_err_yet", proto_err, 0);

        // Reset in SEND_B abandons the triple
        for (int i = 0; i < 20 && req_ready !== 1'b1; i++) @(negedge clk);
        req_valid = 1'b1; a = 32'd9; b = 32'd10; c = 32'd11;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_send_b", data_in, 32'd10);
        #1 rst = 1'b1;
        #1;
        check("async_rst_validi", validi, 0);
        check("async_rst_data_in", data_in, 0);
        check("async_rst_res_valid", res_valid, 0);
        check("async_rst_req_ready", req_ready, 0);
        exp_txn = 16'd0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rel_req_ready", req_ready, 1);
        check("rel_txn_cnt", txn_cnt, 0);
        check("rel_res_valid", res_valid, 0);
        check("rel_proto_err", proto_err, 0);

        // valido while IDLE: sticky flag, FSM unaffected
        valido = 1'b1; data_out = 32'h55;
        @(negedge clk);
        valido = 1'b0;
        check("idle_valido_proto_err", proto_err, 1);
        check("idle_valido_req_ready", req_ready, 1);
        check("idle_valido_res_valid", res_valid, 0);
        run_txn(32'd4, 32'd5, 32'd6, 1, 32'd26, 0);
        check("proto_err_sticky", proto_err, 1);

        check("validi_max_run", max_hi, 3);
        check("validi_min_gap", min_gap, 3);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
